// File: rtl/spi_regfile_periph_if.sv
`default_nettype none
// ============================================================================
// Module   : spi_regfile_periph_if
// Brief    : SPI pin bundle between an SPI controller and the register file.
// Revision : 1.0
// ============================================================================
interface spi_regfile_periph_if;
    logic sclk;
    logic copi;
    logic ncs;
    logic cipo;
    logic cipo_oe;

    modport master (output sclk, output copi, output ncs, input cipo, input cipo_oe);
    modport slave  (input sclk, input copi, input ncs, output cipo, output cipo_oe);
endinterface
`default_nettype wire

// File: rtl/spi_regfile_periph.sv
`default_nettype none
// ============================================================================
// Module   : spi_regfile_periph
// Brief    : SPI mode-0 target with a small writable/readable register file.
// Revision : 1.0
// ============================================================================
module spi_regfile_periph #(
    parameter int NUM_REGS    = 5,
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    spi_regfile_periph_if.slave          spi,
    output logic [NUM_REGS*DATA_W-1:0]   regs,
    output logic [NUM_REGS-1:0]          wr_strobe,
    output logic                         frame_err
);

    localparam int FRAME_LEN = 8 + DATA_W;
    localparam int CNT_W     = $clog2(FRAME_LEN + 2);

    localparam logic [CNT_W-1:0] c_CNT_FRAME     = CNT_W'(FRAME_LEN);
    localparam logic [CNT_W-1:0] c_CNT_SAT       = CNT_W'(FRAME_LEN + 1);
    localparam logic [CNT_W-1:0] c_CNT_CMD_LAST  = CNT_W'(7);
    localparam logic [CNT_W-1:0] c_CNT_DATA_LAST = CNT_W'(FRAME_LEN - 1);
    localparam logic [7:0]       c_NUM_REGS      = 8'(NUM_REGS);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_CMD  = 2'd1;
    localparam logic [1:0] c_DATA = 2'd2;
    localparam logic [1:0] c_DONE = 2'd3;

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_copi_sync;
    logic [SYNC_STAGES-1:0] r_ncs_sync;
    logic [SYNC_STAGES-1:0] r_flush;
    logic                   r_armed;

    logic [1:0]             r_state;
    logic [1:0]             w_state_nxt;
    logic [CNT_W-1:0]       r_bit_cnt;
    logic [FRAME_LEN-1:0]   r_shift_in;
    logic [DATA_W-1:0]      r_shift_out;
    logic                   r_reading;
    logic                   r_cipo;
    logic [DATA_W-1:0]      r_regs [NUM_REGS];
    logic [NUM_REGS-1:0]    r_wr_strobe;
    logic                   r_frame_err;

    logic w_sclk_rise, w_sclk_fall, w_ncs_fall, w_ncs_rise, w_ncs_low, w_copi, w_bit;
    logic w_clr, w_shift_in_en, w_load_out, w_shift_out_en, w_cipo_drive, w_frame_end;
    logic [6:0]        w_cmd_addr;
    logic [DATA_W-1:0] w_rd_data;
    logic              w_frm_rw, w_len_ok, w_addr_ok, w_commit, w_err;
    logic [6:0]        w_frm_addr;
    logic [DATA_W-1:0] w_frm_data;

    // The target arms only once the ncs chain holds post-reset samples that
    // read high, so a frame cut by reset cannot resume mid-stream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sclk_sync <= '0;
            r_copi_sync <= '0;
            r_ncs_sync  <= '1;
            r_flush     <= '0;
            r_armed     <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi.sclk};
            r_copi_sync <= {r_copi_sync[SYNC_STAGES-2:0], spi.copi};
            r_ncs_sync  <= {r_ncs_sync[SYNC_STAGES-2:0], spi.ncs};
            r_flush     <= {r_flush[SYNC_STAGES-2:0], 1'b1};
            if (r_flush[SYNC_STAGES-1] && (&r_ncs_sync)) begin
                r_armed <= 1'b1;
            end
        end
    end

    assign w_sclk_rise = r_sclk_sync[SYNC_STAGES-2] & ~r_sclk_sync[SYNC_STAGES-1];
    assign w_sclk_fall = ~r_sclk_sync[SYNC_STAGES-2] & r_sclk_sync[SYNC_STAGES-1];
    assign w_ncs_fall  = ~r_ncs_sync[SYNC_STAGES-2] & r_ncs_sync[SYNC_STAGES-1] & r_armed;
    assign w_ncs_rise  = r_ncs_sync[SYNC_STAGES-2] & ~r_ncs_sync[SYNC_STAGES-1];
    assign w_ncs_low   = ~r_ncs_sync[SYNC_STAGES-1];
    assign w_copi      = r_copi_sync[SYNC_STAGES-1];
    assign w_bit       = w_sclk_rise & w_ncs_low & (r_state != c_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (w_ncs_fall) w_state_nxt = c_CMD;
            c_CMD:   if (w_bit && (r_bit_cnt == c_CNT_CMD_LAST)) w_state_nxt = c_DATA;
            c_DATA:  if (w_bit && (r_bit_cnt == c_CNT_DATA_LAST)) w_state_nxt = c_DONE;
            default: w_state_nxt = r_state;
        endcase
        if (w_ncs_rise) begin
            w_state_nxt = c_IDLE;
        end
    end

    always_comb begin
        w_clr          = (r_state == c_IDLE) & w_ncs_fall;
        w_shift_in_en  = w_bit & ((r_state == c_CMD) | (r_state == c_DATA));
        w_load_out     = w_bit & (r_state == c_CMD) & (r_bit_cnt == c_CNT_CMD_LAST);
        w_cipo_drive   = (r_state == c_DATA) & r_reading;
        w_shift_out_en = w_cipo_drive & w_sclk_fall & w_ncs_low;
        w_frame_end    = w_ncs_rise & (r_state != c_IDLE);
    end

    // Address is complete on the 8th sample: seven bits already shifted plus copi now.
    assign w_cmd_addr = {r_shift_in[5:0], w_copi};

    always_comb begin
        w_rd_data = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (w_cmd_addr == 7'(i)) begin
                w_rd_data = r_regs[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt   <= '0;
            r_shift_in  <= '0;
            r_shift_out <= '0;
            r_reading   <= 1'b0;
            r_cipo      <= 1'b0;
        end else begin
            if (w_clr) begin
                r_bit_cnt <= '0;
            end else if (w_bit && (r_bit_cnt != c_CNT_SAT)) begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end

            if (w_clr) begin
                r_shift_in <= '0;
            end else if (w_shift_in_en) begin
                r_shift_in <= {r_shift_in[FRAME_LEN-2:0], w_copi};
            end

            if (w_clr) begin
                r_reading <= 1'b0;
            end else if (w_load_out) begin
                r_reading <= ~r_shift_in[6];
            end

            if (w_load_out) begin
                r_shift_out <= w_rd_data;
            end else if (w_shift_out_en) begin
                r_shift_out <= {r_shift_out[DATA_W-2:0], 1'b0};
            end

            if (!w_cipo_drive) begin
                r_cipo <= 1'b0;
            end else if (w_shift_out_en) begin
                r_cipo <= r_shift_out[DATA_W-1];
            end
        end
    end

    // Frame fields are decoded from the held shift register after ncs rises.
    assign w_frm_rw   = r_shift_in[FRAME_LEN-1];
    assign w_frm_addr = r_shift_in[FRAME_LEN-2 -: 7];
    assign w_frm_data = r_shift_in[DATA_W-1:0];
    assign w_len_ok   = (r_bit_cnt == c_CNT_FRAME);
    assign w_addr_ok  = ({1'b0, w_frm_addr} < c_NUM_REGS);
    assign w_commit   = w_frame_end & w_len_ok & w_frm_rw & w_addr_ok;
    assign w_err      = w_frame_end & (~w_len_ok | (w_frm_rw & ~w_addr_ok));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_strobe <= '0;
            r_frame_err <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            r_frame_err <= w_err;
            for (int i = 0; i < NUM_REGS; i++) begin
                r_wr_strobe[i] <= w_commit && (w_frm_addr == 7'(i));
                if (w_commit && (w_frm_addr == 7'(i))) begin
                    r_regs[i] <= w_frm_data;
                end
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_flat
            assign regs[gi*DATA_W +: DATA_W] = r_regs[gi];
        end
    endgenerate

    assign wr_strobe   = r_wr_strobe;
    assign frame_err   = r_frame_err;
    assign spi.cipo    = r_cipo;
    assign spi.cipo_oe = w_ncs_low;

endmodule
`default_nettype wire

// File: doc/spi_regfile_periph.md
SPI_REGFILE_PERIPH -- requirements
Module: spi_regfile_periph

Interface
REQ-001 SHALL provide parameter NUM_REGS, default 5: number of writable/readable registers (1..128).
REQ-002 SHALL provide parameter DATA_W, default 8: register width in bits.
REQ-003 SHALL provide parameter SYNC_STAGES, default 2: synchronizer depth on sclk/copi/ncs (>=2).
REQ-004 SHALL provide port clk  input  1: system clock; all logic on posedge clk.
REQ-005 SHALL provide port rst_n  input  1: reset, asynchronous, active-low.
REQ-006 SHALL provide port sclk  input  1: SPI clock from controller, async to clk.
REQ-007 SHALL provide port copi  input  1: serial data from controller.
REQ-008 SHALL provide port ncs  input  1: chip select, active low.
REQ-009 SHALL provide port cipo  output  1: serial readback data to controller.
REQ-010 SHALL provide port cipo_oe  output  1: high while synchronized ncs is low.
REQ-011 SHALL provide port regs  output  NUM_REGS*DATA_W: register contents flat; reg i at bits [i*DATA_W +: DATA_W].
REQ-012 SHALL provide port wr_strobe  output  NUM_REGS: one-cycle pulse per register on commit.
REQ-013 SHALL provide port frame_err  output  1: one-cycle pulse on rejected frame.

Function
REQ-014 SHALL pass sclk, copi, ncs through SYNC_STAGES flops each; edges detected from the last two stages only.
REQ-015 Frame SHALL be FRAME_LEN = 8+DATA_W bits, MSB first: bit0 = R/W (1 = write), next 7 bits = address, then DATA_W data bits.
REQ-016 SHALL use SPI mode 0: sample copi on synchronized sclk rising edge, update cipo on falling edge.
REQ-017 State machine SHALL be IDLE, CMD (R/W+address, 8 bits), DATA (DATA_W bits), DONE (wait for ncs high).
REQ-018 IDLE->CMD on ncs falling edge; bit counter and shift register cleared on that edge.
REQ-019 CMD->DATA after 8th sampled bit; DATA->DONE after FRAME_LEN-th bit.
REQ-020 Any state->IDLE on ncs rising edge.
REQ-021 Read frame (R/W=0): on CMD->DATA, load output shift register with reg[addr], or all zeros if addr >= NUM_REGS; shift out MSB first on subsequent falling edges; cipo holds 0 outside read data phase.
REQ-022 Commit SHALL occur exactly one clk after ncs rising edge detection, only if write, bit count == FRAME_LEN, and addr < NUM_REGS.
REQ-023 On commit: regs[addr] <= data field, wr_strobe[addr] pulses for one cycle; other registers unchanged.
REQ-024 Bit count != FRAME_LEN (short frame), or extra sclk rising edges in DONE (overrun), SHALL discard the frame and pulse frame_err in the commit cycle.
REQ-025 Write to addr >= NUM_REGS with correct length SHALL be discarded and pulse frame_err; read to such addr SHALL not pulse frame_err.
REQ-026 sclk edges while synchronized ncs is high SHALL be ignored.
REQ-027 Back-to-back frames with ncs high for >= SYNC_STAGES+2 clk SHALL all be processed.
REQ-028 Bit counter SHALL saturate at FRAME_LEN+1; no wrap-around.

Reset
REQ-029 On rst_n low: all regs = 0, wr_strobe = 0, frame_err = 0, cipo = 0, cipo_oe = 0, state = IDLE, synchronizers = idle values (sclk 0, ncs 1, copi 0).
REQ-030 Reset asserted mid-frame SHALL abort the frame; after release, ncs must rise and fall again before any bits are accepted.

Verification
REQ-031 Write 0x80|addr=2, data 0xA5 (DATA_W=8) -> regs[2]=0xA5, wr_strobe[2] one pulse, frame_err stays 0.
REQ-032 Write addr=7 with NUM_REGS=5 -> no register change, frame_err one pulse.
REQ-033 Write of 12 bits then ncs high -> no change, frame_err pulse; 17 bits -> same.
REQ-034 After writing 0x3C to reg 1, read frame addr=1 -> cipo emits 0x3C MSB first during data phase; read addr=9 -> 0x00, no frame_err.
REQ-035 Reset pulsed after 10 bits of a write -> all regs 0, no wr_strobe; next full write commits normally.
REQ-036 Parameter sweep NUM_REGS=1,16 and DATA_W=8,16 -> REQ-031/034 pass with FRAME_LEN=8+DATA_W.
